team_12_wb_master: RTL

- Single-outstanding Wishbone B4 classic initiator for the team_12 design.
- Drives the wrapper's master-side bus (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I) toward the nebula_ii Wishbone arbitrator.
- Internal logic issues one read or write through a valid/ready request port and gets one response pulse back.
- A bounded ACK wait keeps a stalled arbitrator or absent slave from hanging the design.

---
 rtl/team_12_wbm_pkg.sv | 23 ++
 rtl/team_12_wb_master_if.sv | 25 ++
 rtl/team_12_wbm_timeout.sv | 32 +++
 rtl/team_12_wb_master.sv | 122 ++++++++++++
 4 files changed

// File: rtl/team_12_wbm_pkg.sv
// Shared types and constants for the team_12 Wishbone B4 classic initiator.
// Optional feature macro: TEAM_12_WBM_TIMEOUT_EN (ACK timeout counter).
package team_12_wbm_pkg;

  localparam int unsigned WB_ADR_W            = 32;
  localparam int unsigned WB_DAT_W            = 32;
  localparam int unsigned WB_SEL_W            = 4;
  localparam int unsigned WBM_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wbm_state_t;

  // Payload held on the bus for the duration of one cycle
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_cmd_t;

endpackage

// File: rtl/team_12_wb_master_if.sv
// Wishbone B4 classic bus between the team_12 initiator and the arbitrator.
// Optional feature macro: TEAM_12_WBM_TIMEOUT_EN (no effect on this file).
interface team_12_wb_master_if;
  import team_12_wbm_pkg::*;

  logic [WB_ADR_W-1:0] ADR_O;
  logic [WB_DAT_W-1:0] DAT_O;
  logic [WB_SEL_W-1:0] SEL_O;
  logic                WE_O;
  logic                STB_O;
  logic                CYC_O;
  logic [WB_DAT_W-1:0] DAT_I;
  logic                ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );

endinterface

// File: rtl/team_12_wbm_timeout.sv
// ACK wait counter: cleared outside a bus cycle, counts cycles without ACK.
// Only instantiated when TEAM_12_WBM_TIMEOUT_EN is defined.
module team_12_wbm_timeout
  import team_12_wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] cnt_q;

  // Wait counter; holds at the limit so it can never wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  assign expired_c = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/team_12_wb_master.sv
// Single-outstanding Wishbone B4 classic initiator with valid/ready request
// port and one-cycle response pulse.
// Optional feature macro: TEAM_12_WBM_TIMEOUT_EN (abort after TIMEOUT_CYCLES
// without ACK_I); when undefined the bus cycle waits for ACK_I forever.
module team_12_wb_master
  import team_12_wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WB_ADR_W-1:0] req_adr,
  input  logic [WB_DAT_W-1:0] req_dat,
  input  logic [WB_SEL_W-1:0] req_sel,
  output logic                resp_valid,
  output logic [WB_DAT_W-1:0] resp_dat,
  output logic                resp_err,
  team_12_wb_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("team_12_wb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  wbm_state_t          state_q, state_d;
  wb_cmd_t             cmd_q, cmd_d;
  logic                cyc_q, cyc_d;
  logic                resp_valid_d;
  logic                resp_err_d;
  logic [WB_DAT_W-1:0] resp_dat_d;
  logic                expired_c;

`ifdef TEAM_12_WBM_TIMEOUT_EN
  team_12_wbm_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (state_q == IDLE),
    .en        ((state_q == BUS) && !bus.ACK_I),
    .expired_c (expired_c)
  );
`else
  assign expired_c = 1'b0;
`endif

  // State, bus payload and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cyc_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_dat   <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cyc_q      <= cyc_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_dat   <= resp_dat_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cyc_d        = cyc_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_dat_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sel == '0) begin
            // No byte lanes: reject without touching the bus
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = BUS;
            cyc_d     = 1'b1;
            cmd_d.adr = {req_adr[WB_ADR_W-1:2], 2'b00};
            cmd_d.dat = req_we ? req_dat : '0;
            cmd_d.sel = req_sel;
            cmd_d.we  = req_we;
          end
        end
      end
      BUS: begin
        // ACK takes priority over an expiring timeout
        if (bus.ACK_I) begin
          state_d      = IDLE;
          cyc_d        = 1'b0;
          cmd_d.we     = 1'b0;
          resp_valid_d = 1'b1;
          resp_dat_d   = cmd_q.we ? '0 : bus.DAT_I;
        end else if (expired_c) begin
          state_d      = IDLE;
          cyc_d        = 1'b0;
          cmd_d.we     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign bus.ADR_O = cmd_q.adr;
  assign bus.DAT_O = cmd_q.dat;
  assign bus.SEL_O = cmd_q.sel;
  assign bus.WE_O  = cmd_q.we;
  assign bus.STB_O = cyc_q;
  assign bus.CYC_O = cyc_q;

endmodule
